compare_sequencer: RTL

//  Sequencer for the 4-bit COMPARISON datapath. It accepts a burst of LEN 4-bit operands and

---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_operand_buf.sv | 22 ++
 rtl/compare_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparison sequencer: comparator opcodes and FSM states.
package cmp_pkg;

  localparam logic [1:0] OP_EQ  = 2'b00;
  localparam logic [1:0] OP_GT  = 2'b01;
  localparam logic [1:0] OP_LT  = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_operand_buf.sv
// DEPTH x 4-bit operand register file: synchronous write, combinational read, no reset.
module cmp_operand_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [3:0]    rdata_o
);

  logic [3:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/compare_sequencer.sv
// Loads a burst of 4-bit operands while tracking the running maximum through an external
// comparator in MAX mode, then rescans the buffer in EQUAL mode to count copies of the maximum.
module compare_sequencer
  import cmp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [3:0]       din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic [7:0]       cmp_number_o,
  output logic [1:0]       cmp_op_o,
  input  logic [9:0]       cmp_f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       max_out_o,
  output logic [CNT_W-1:0] eq_count_o
);

  localparam int AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] eq_count_q, eq_count_d;
  logic [3:0]       run_max_q, run_max_d;
  logic [3:0]       max_out_q, max_out_d;
  logic             buf_we;
  logic [3:0]       buf_rdata;
  logic             last_idx;
  logic             unused_cmp_f;

  assign unused_cmp_f = ^cmp_f_i[9:4];
  assign last_idx     = (idx_q == len_q - CNT_W'(1));

  cmp_operand_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (din_i),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    eq_cnt_d   = eq_cnt_q;
    eq_count_d = eq_count_q;
    run_max_d  = run_max_q;
    max_out_d  = max_out_q;
    buf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d      = (len_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len_i;
          idx_d      = '0;
          eq_cnt_d   = '0;
          run_max_d  = '0;
          max_out_d  = '0;
          eq_count_d = '0;
          state_d    = (len_i == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (din_valid_i) begin
          buf_we    = 1'b1;
          run_max_d = cmp_f_i[3:0];
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_SCAN;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      ST_SCAN: begin
        eq_cnt_d = eq_cnt_q + CNT_W'(cmp_f_i[0]);
        if (last_idx) begin
          max_out_d  = run_max_q;
          eq_count_d = eq_cnt_q + CNT_W'(cmp_f_i[0]);
          state_d    = ST_DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      eq_cnt_q   <= '0;
      eq_count_q <= '0;
      run_max_q  <= '0;
      max_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      eq_cnt_q   <= eq_cnt_d;
      eq_count_q <= eq_count_d;
      run_max_q  <= run_max_d;
      max_out_q  <= max_out_d;
    end
  end

  // Comparator operands are decoded from registered state; only the live DIN passes straight through in LOAD.
  always_comb begin
    din_ready_o  = (state_q == ST_LOAD);
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    cmp_op_o     = OP_EQ;
    cmp_number_o = '0;
    case (state_q)
      ST_LOAD: begin
        cmp_op_o     = OP_MAX;
        cmp_number_o = {run_max_q, din_i};
      end
      ST_SCAN: cmp_number_o = {run_max_q, buf_rdata};
      default: ;
    endcase
  end

  assign max_out_o  = max_out_q;
  assign eq_count_o = eq_count_q;

endmodule
